// File: rtl/absorb_stream.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// absorb_stream : Keccak sponge absorb stage (64-bit lanes, SHAKE 0x1F padding)
// Rev 1.0
// ============================================================================
module absorb_stream #(
    parameter int RATE        = 1088,
    parameter int STATE_WIDTH = 1600
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [63:0]            in_data_i,
    input  logic                   in_valid_i,
    input  logic                   in_last_i,
    input  logic [3:0]             in_bytes_i,
    output logic                   in_ready_o,
    output logic                   perm_start_o,
    output logic [STATE_WIDTH-1:0] perm_in_o,
    input  logic [STATE_WIDTH-1:0] perm_out_i,
    input  logic                   perm_done_i,
    output logic [STATE_WIDTH-1:0] state_out_o,
    output logic                   absorb_done_o
);

    localparam int c_LANES      = RATE / 64;
    localparam int c_RATE_BYTES = RATE / 8;
    localparam int c_LIDX_W     = (c_LANES > 1) ? $clog2(c_LANES) : 1;
    localparam int c_POFF_W     = $clog2(c_RATE_BYTES + 1);

    localparam logic [c_LIDX_W-1:0] c_LAST_LANE = c_LIDX_W'(c_LANES - 1);
    localparam logic [c_POFF_W-1:0] c_PAD_FULL  = c_POFF_W'(c_RATE_BYTES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_PAD  = 3'd2,
        S_PERM = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                  fsm_q;
    logic [STATE_WIDTH-1:0]  state_q;
    logic [c_LIDX_W-1:0]     lane_idx_q;
    logic [c_POFF_W-1:0]     pad_off_q;
    logic                    final_pending_q;
    logic                    pad_pending_q;
    logic                    in_ready_q;
    logic                    perm_start_q;
    logic                    absorb_done_q;

    logic [3:0]              w_nbytes;
    logic [63:0]             w_word_masked;
    logic [c_POFF_W-1:0]     w_pad_off;
    logic [STATE_WIDTH-1:0]  absorb_d;
    logic [STATE_WIDTH-1:0]  pad_d;

    // Byte count of the final word, saturated at a full lane.
    assign w_nbytes  = (in_bytes_i > 4'd8) ? 4'd8 : in_bytes_i;
    assign w_pad_off = c_POFF_W'({lane_idx_q, 3'b000}) + c_POFF_W'(w_nbytes);

    always_comb begin
        w_word_masked = '0;
        for (int b = 0; b < 8; b++) begin
            w_word_masked[b*8 +: 8] = (!in_last_i || (4'(b) < w_nbytes)) ?
                                      in_data_i[b*8 +: 8] : 8'h00;
        end
    end

    always_comb begin
        absorb_d = state_q;
        for (int l = 0; l < c_LANES; l++) begin
            if (lane_idx_q == c_LIDX_W'(l)) begin
                absorb_d[l*64 +: 64] = state_q[l*64 +: 64] ^ w_word_masked;
            end
        end
    end

    // Both pad bytes are XORed in sequence so a shared byte collapses to 0x9F.
    always_comb begin
        pad_d = state_q;
        for (int b = 0; b < c_RATE_BYTES; b++) begin
            if (pad_off_q == c_POFF_W'(b)) begin
                pad_d[b*8 +: 8] = state_q[b*8 +: 8] ^ 8'h1F;
            end
        end
        pad_d[RATE-8 +: 8] = pad_d[RATE-8 +: 8] ^ 8'h80;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            fsm_q           <= S_IDLE;
            state_q         <= '0;
            lane_idx_q      <= '0;
            pad_off_q       <= '0;
            final_pending_q <= 1'b0;
            pad_pending_q   <= 1'b0;
            in_ready_q      <= 1'b0;
            perm_start_q    <= 1'b0;
            absorb_done_q   <= 1'b0;
        end else begin
            perm_start_q <= 1'b0;
            case (fsm_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q         <= '0;
                        lane_idx_q      <= '0;
                        pad_off_q       <= '0;
                        final_pending_q <= 1'b0;
                        pad_pending_q   <= 1'b0;
                        in_ready_q      <= 1'b1;
                        absorb_done_q   <= 1'b0;
                        fsm_q           <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid_i) begin
                        state_q <= absorb_d;
                        if (in_last_i) begin
                            in_ready_q <= 1'b0;
                            if (w_pad_off == c_PAD_FULL) begin
                                // Block filled exactly: padding goes into a fresh block.
                                pad_pending_q <= 1'b1;
                                perm_start_q  <= 1'b1;
                                fsm_q         <= S_PERM;
                            end else begin
                                pad_off_q <= w_pad_off;
                                fsm_q     <= S_PAD;
                            end
                        end else if (lane_idx_q == c_LAST_LANE) begin
                            lane_idx_q   <= '0;
                            in_ready_q   <= 1'b0;
                            perm_start_q <= 1'b1;
                            fsm_q        <= S_PERM;
                        end else begin
                            lane_idx_q <= lane_idx_q + c_LIDX_W'(1);
                        end
                    end
                end
                S_PAD: begin
                    state_q         <= pad_d;
                    final_pending_q <= 1'b1;
                    perm_start_q    <= 1'b1;
                    fsm_q           <= S_PERM;
                end
                S_PERM: begin
                    if (perm_done_i) begin
                        state_q <= perm_out_i;
                        if (pad_pending_q) begin
                            pad_pending_q <= 1'b0;
                            pad_off_q     <= '0;
                            fsm_q         <= S_PAD;
                        end else if (final_pending_q) begin
                            absorb_done_q <= 1'b1;
                            fsm_q         <= S_DONE;
                        end else begin
                            in_ready_q <= 1'b1;
                            fsm_q      <= S_LOAD;
                        end
                    end
                end
                default: begin
                    in_ready_q    <= 1'b0;
                    absorb_done_q <= 1'b0;
                    fsm_q         <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o    = in_ready_q;
    assign perm_start_o  = perm_start_q;
    assign perm_in_o     = state_q;
    assign state_out_o   = state_q;
    assign absorb_done_o = absorb_done_q;

endmodule
`default_nettype wire

// File: tb/tb_absorb_stream.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// tb_absorb_stream : self-checking bench for absorb_stream with a stand-in permutation
// Rev 1.0
// ============================================================================
module tb_absorb_stream;

    localparam int SW = 1600;
    localparam int RB = 136;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          start_i = 1'b0;
    logic [63:0]   in_data_i = '0;
    logic          in_valid_i = 1'b0;
    logic          in_last_i = 1'b0;
    logic [3:0]    in_bytes_i = '0;
    logic          in_ready_o;
    logic          perm_start_o;
    logic [SW-1:0] perm_in_o;
    logic [SW-1:0] perm_out_i;
    logic          perm_done_i;
    logic [SW-1:0] state_out_o;
    logic          absorb_done_o;

    logic          resp_done = 1'b0;
    logic [SW-1:0] resp_out = '0;
    logic          man_done = 1'b0;
    logic [SW-1:0] man_out = '0;

    assign perm_done_i = resp_done | man_done;
    assign perm_out_i  = man_done ? man_out : resp_out;

    always #5 clk = ~clk;

    absorb_stream #(.RATE(1088), .STATE_WIDTH(SW)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .in_data_i    (in_data_i),
        .in_valid_i   (in_valid_i),
        .in_last_i    (in_last_i),
        .in_bytes_i   (in_bytes_i),
        .in_ready_o   (in_ready_o),
        .perm_start_o (perm_start_o),
        .perm_in_o    (perm_in_o),
        .perm_out_i   (perm_out_i),
        .perm_done_i  (perm_done_i),
        .state_out_o  (state_out_o),
        .absorb_done_o(absorb_done_o)
    );

    int            total = 0;
    int            bad = 0;
    int            resp_delay = 0;
    bit            resp_en = 1'b1;
    int            nstarts = 0;
    logic [SW-1:0] cap_q[$];
    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] exp_final;
    logic [7:0]    msg[0:511];

    typedef struct {
        int len;
        int dly;
        int gap;
        int perms;
    } vec_t;

    // Stand-in permutation: any fixed bijection touching every bit will do.
    function automatic logic [SW-1:0] fperm(input logic [SW-1:0] s);
        return ~{s[SW-2:0], s[SW-1]} ^ {25{64'h9E3779B97F4A7C15}};
    endfunction

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        int l;
        l = 0;
        total++;
        if (act !== exp) begin
            bad++;
            for (int i = 24; i >= 0; i--) begin
                if (act[i*64 +: 64] !== exp[i*64 +: 64]) l = i;
            end
            $display("FAIL %s: lane %0d got %016h expected %016h",
                     name, l, act[l*64 +: 64], exp[l*64 +: 64]);
        end
    endtask

    // Permutation responder: captures perm_in, answers after resp_delay cycles.
    initial begin
        logic [SW-1:0] pin;
        forever begin
            @(negedge clk);
            if (resp_en && perm_start_o === 1'b1) begin
                pin = perm_in_o;
                cap_q.push_back(pin);
                nstarts++;
                for (int i = 0; i < resp_delay; i++) begin
                    @(negedge clk);
                    chk_int("ready_low_in_perm", int'(in_ready_o), 0);
                    chk_int("perm_start_single", int'(perm_start_o), 0);
                end
                resp_out  = fperm(pin);
                resp_done = 1'b1;
                @(negedge clk);
                resp_done = 1'b0;
            end
        end
    end

    task automatic run_msg(input string tag, input int n, input int dly, input int gap, input int exp_perms);
        logic [7:0]    pb[0:543];
        logic [SW-1:0] s;
        logic [63:0]   d;
        int            nblk, nw, nb, t, idx;

        resp_delay = dly;
        cap_q.delete();
        exp_q.delete();
        nstarts = 0;
        for (int i = 0; i < n; i++) msg[i] = 8'($urandom);

        // Reference: pad the whole message, then XOR block by block and permute.
        nblk = n / RB + 1;
        for (int i = 0; i < nblk * RB; i++) pb[i] = (i < n) ? msg[i] : 8'h00;
        pb[n] = pb[n] ^ 8'h1F;
        pb[nblk*RB-1] = pb[nblk*RB-1] ^ 8'h80;
        s = '0;
        for (int k = 0; k < nblk; k++) begin
            for (int j = 0; j < RB; j++) s[8*j +: 8] = s[8*j +: 8] ^ pb[k*RB + j];
            exp_q.push_back(s);
            s = fperm(s);
        end
        exp_final = s;

        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;

        nw = (n == 0) ? 1 : (n + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            while (gap > 0 && int'($urandom_range(0, 99)) < gap) begin
                in_valid_i = 1'b0;
                @(negedge clk);
            end
            for (int b = 0; b < 8; b++) begin
                idx = 8*w + b;
                d[8*b +: 8] = (idx < n) ? msg[idx] : 8'($urandom);
            end
            in_data_i = d;
            in_last_i = (w == nw - 1);
            nb = n - 8*w;
            if (nb >= 8) nb = 8 + int'($urandom_range(0, 7));
            in_bytes_i = (w == nw - 1) ? 4'(nb) : 4'($urandom);
            in_valid_i = 1'b1;
            t = 0;
            while (in_ready_o !== 1'b1 && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (t >= 300) begin
                chk_int({tag, "_ready_timeout"}, t, 0);
                in_valid_i = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;

        t = 0;
        while (absorb_done_o !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk_int({tag, "_done"}, int'(absorb_done_o), 1);
        chk_int({tag, "_perm_count"}, nstarts, exp_perms);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < cap_q.size()) chk_vec({tag, "_perm_in"}, cap_q[k], exp_q[k]);
        end
        chk_vec({tag, "_state_out"}, state_out_o, exp_final);
    endtask

    initial begin
        vec_t          vecs[10];
        logic [SW-1:0] tmp;
        int            t;

        vecs[0] = '{0,   0, 0,  1};
        vecs[1] = '{5,   1, 30, 1};
        vecs[2] = '{8,   0, 0,  1};
        vecs[3] = '{64,  2, 20, 1};
        vecs[4] = '{135, 1, 25, 1};
        vecs[5] = '{136, 0, 0,  2};
        vecs[6] = '{137, 4, 30, 2};
        vecs[7] = '{200, 1, 10, 2};
        vecs[8] = '{272, 2, 20, 3};
        vecs[9] = '{300, 5, 40, 3};

        repeat (3) @(negedge clk);
        chk_int("rst_in_ready", int'(in_ready_o), 0);
        chk_int("rst_perm_start", int'(perm_start_o), 0);
        chk_int("rst_absorb_done", int'(absorb_done_o), 0);
        chk_vec("rst_state_out", state_out_o, '0);
        reset_i = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_msg($sformatf("vec%0d", i), vecs[i].len, vecs[i].dly, vecs[i].gap, vecs[i].perms);
        end

        run_msg("empty", 0, 2, 0, 1);
        tmp = '0;
        tmp[7:0] = 8'h1F;
        tmp[1087:1080] = 8'h80;
        if (cap_q.size() > 0) chk_vec("empty_perm_in", cap_q[0], tmp);
        chk_vec("empty_state_out", state_out_o, fperm(tmp));

        run_msg("m135", 135, 1, 0, 1);
        if (cap_q.size() > 0) chk_int("m135_byte135", int'(cap_q[0][1087:1080]), 8'h9F);

        run_msg("m136", 136, 3, 0, 2);
        if (cap_q.size() > 1) begin
            tmp = fperm(cap_q[0]);
            tmp[7:0] = tmp[7:0] ^ 8'h1F;
            tmp[1087:1080] = tmp[1087:1080] ^ 8'h80;
            chk_vec("m136_second_perm_in", cap_q[1], tmp);
        end

        // start held high in DONE restarts and clears the state.
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        chk_int("restart_done_low", int'(absorb_done_o), 0);
        chk_int("restart_ready", int'(in_ready_o), 1);
        chk_vec("restart_state_zero", state_out_o, '0);
        @(negedge clk);
        start_i = 1'b0;
        run_msg("after_restart", 16, 1, 0, 1);

        // Reset while the permutation is outstanding, then a stale perm_done.
        resp_en = 1'b0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i    = 1'b0;
        in_data_i  = 64'h0123456789ABCDEF;
        in_last_i  = 1'b1;
        in_bytes_i = 4'd3;
        in_valid_i = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        t = 0;
        while (perm_start_o !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk_int("abort_perm_started", int'(perm_start_o), 1);
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b1;
        man_out  = fperm({25{64'hA5A5_5A5A_F0F0_0F0F}});
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_int("abort_ready", int'(in_ready_o), 0);
            chk_int("abort_perm_start", int'(perm_start_o), 0);
            chk_int("abort_done", int'(absorb_done_o), 0);
            chk_vec("abort_state", state_out_o, '0);
            @(negedge clk);
        end
        resp_en = 1'b1;
        run_msg("post_reset", 20, 2, 20, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/absorb_stream.md
ABSORB_STREAM -- requirements
Module: absorb_stream

Interface
REQ-001 Parameters: RATE, 1088, rate bits (multiple of 64); STATE_WIDTH, 1600, Keccak state bits; LANES = RATE/64 (17) derived, not overridable.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 start  in  1  begin new absorb; sampled only in IDLE and DONE.
REQ-005 in_data  in  64  message word; byte k at bits 8k+7:8k (little-endian lane order).
REQ-006 in_valid  in  1  in_data/in_last/in_bytes valid.
REQ-007 in_last  in  1  final message word.
REQ-008 in_bytes  in  4  valid bytes in the in_last word, 0..8; ignored when in_last=0; values >8 treated as 8.
REQ-009 in_ready  out  1  block accepts a word this cycle.
REQ-010 perm_start  out  1  one-cycle pulse requesting Keccak-f[1600] on perm_in.
REQ-011 perm_in  out  STATE_WIDTH  state presented to permutation core (equals state_reg).
REQ-012 perm_out  in  STATE_WIDTH  permuted state, valid when perm_done=1.
REQ-013 perm_done  in  1  permutation result valid (one-cycle pulse).
REQ-014 state_out  out  STATE_WIDTH  absorbed state, valid while absorb_done=1.
REQ-015 absorb_done  out  1  level; absorption and final permutation complete.

Function
REQ-016 FSM states IDLE, LOAD, PAD, PERM, DONE; lane index lane_idx 0..LANES-1; flags final_pending, pad_pending.
REQ-017 IDLE: start=1 -> state_reg cleared to 0, lane_idx=0, flags cleared, next LOAD.
REQ-018 LOAD: in_ready=1; word accepted when in_valid && in_ready.
REQ-019 Accepted non-last word: lane[lane_idx] ^= in_data; if lane_idx==LANES-1 -> lane_idx=0, next PERM; else lane_idx+1.
REQ-020 Accepted last word: lane[lane_idx] ^= in_data with bytes >= in_bytes masked to zero; pad offset p = 8*lane_idx + in_bytes (bytes).
REQ-021 Last word with p < RATE/8 -> next PAD with pad offset p.
REQ-022 Last word with p == RATE/8 (block exactly full) -> set pad_pending, next PERM; on return, PAD with p=0.
REQ-023 PAD (one cycle): byte p ^= 0x1F and byte RATE/8-1 ^= 0x80 (p == RATE/8-1 yields 0x9F); set final_pending; next PERM.
REQ-024 PERM: perm_start=1 only on entry cycle; state_reg held; in_ready=0; wait any number of cycles for perm_done.
REQ-025 perm_done in PERM: state_reg <= perm_out; then pad_pending -> clear it, PAD; else final_pending -> DONE; else LOAD.
REQ-026 perm_done outside PERM ignored.
REQ-027 DONE: absorb_done=1, state_out=state_reg; start=1 -> same action as REQ-017, absorb_done drops next cycle.
REQ-028 start in LOAD, PAD or PERM ignored.
REQ-029 in_ready=0 in all states except LOAD; in_valid with in_ready=0 has no effect.
REQ-030 Latency: last word accepted (p<RATE/8) -> PAD next cycle -> perm_start following cycle -> absorb_done one cycle after perm_done.
REQ-031 Only rate lanes 0..LANES-1 XORed by input/padding; capacity bits change only via perm_out.

Reset
REQ-032 reset=0 at a rising edge: FSM IDLE, state_reg 0, lane_idx 0, flags 0; in_ready 0, perm_start 0, absorb_done 0, state_out 0.
REQ-033 Reset mid-PERM aborts; a later perm_done is ignored; no partial state retained.

Verification
REQ-034 Empty message: start, one word in_last=1 in_bytes=0 -> lane0=0x1F, byte 135=0x80 at perm_in, exactly one perm_start, absorb_done after perm_done, state_out=perm_out.
REQ-035 135-byte message (17 words, last in_bytes=7) -> byte 135 of perm_in = msg^0x9F, one perm_start.
REQ-036 136-byte message (last in_bytes=8) -> two perm_starts; second perm_in = perm_out1 with lane0^0x1F, byte 135^0x80.
REQ-037 300-byte message, perm_done delayed 5 cycles, random in_valid gaps -> in_ready=0 throughout PERM, three perm_starts, state matches SHAKE256 reference model.
REQ-038 reset=0 during PERM, then perm_done pulse -> stays IDLE, all outputs 0; new start absorbs correctly.
REQ-039 start held high in DONE -> restart, absorb_done low next cycle, state_reg 0.
